riscv_muldiv_unit: RTL
======================

# riscv_muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in `DATA_WIDTH`, that extends the core's single-cycle ALU with all eight M-extension operations. It sits beside the ALU in the execute stage. It is started by the control unit, holds the core stalled through `busy`, and returns its result on a one-cycle `done` pulse for the register-file write-back mux.

## Interface
- `DATA_WIDTH`, 32: operand and result width; must be even and ≥ 8.
- `CNT_WIDTH`, `$clog2(DATA_WIDTH+1)`: iteration counter width (derived, do not override).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `start`  in  1  launch operation; sampled only in IDLE or DONE.
- `abort`  in  1  pipeline flush; cancels an in-flight operation.
- `funct3`  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  DATA_WIDTH  rs1 operand, captured when start is accepted.
- `b`  in  DATA_WIDTH  rs2 operand, captured when start is accepted.
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  one-cycle pulse in DONE; `result` is valid.
- `result`  out  DATA_WIDTH  registered result; held until the next accepted start completes.

## Operation
- Reset values: state IDLE; `busy` = 0, `done` = 0, `result` = 0; counter and all internal registers 0.
- States:
  - IDLE → CALC on start.
  - IDLE → DONE on start when the op is a special case.
  - CALC → FIX when the counter reaches `DATA_WIDTH`.
  - FIX → DONE.
  - DONE → IDLE, or → CALC/DONE again if start is high (back-to-back accept).
- Operand prep at accept: signed operands are converted to magnitudes and the sign flags are latched.
  - MULH: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - DIV and REM: both operands signed.
  - MUL, MULHU, DIVU, REMU: operands treated as unsigned.
- Multiply: shift-add over 2·`DATA_WIDTH`-bit product register, one bit per cycle, `DATA_WIDTH` cycles.
  - FIX negates the product if the two sign flags differ.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide: restoring division, one quotient bit per cycle, `DATA_WIDTH` cycles.
  - FIX negates the quotient if the sign flags differ.
  - FIX negates the remainder if the dividend sign flag is set.
- Special cases skip CALC and FIX and go straight to DONE:
  - Divide by zero (`b` = 0): quotient = all ones; remainder = `a`.
  - Signed overflow (DIV/REM, `a` = most negative value, `b` = −1): quotient = `a`; remainder = 0.
- Abort:
  - In CALC or FIX: next state IDLE, no `done`, `result` unchanged.
  - In DONE: no effect; the pulse is already issued.
  - Abort has priority over a simultaneous start; that start is dropped.
- Start while `busy` is ignored. Operand inputs are don't-care except in the accept cycle.
- `rst` mid-operation: return to reset values on the next edge. No `done` is issued.

## Timing
- Accept edge = cycle 0.
- Normal op:
  - `busy` high in cycles 1..`DATA_WIDTH`+1.
  - `done` high in cycle `DATA_WIDTH`+2 (34 for 32-bit).
- Special case: `done` high in cycle 1; `busy` never asserted.
- `result` updates on the same edge that enters DONE. It is stable from the `done` cycle onward.
- Back-to-back: start accepted in a DONE cycle gives a new `done` at +`DATA_WIDTH`+2 with no IDLE gap.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `MulDiv_pkg` (alongside `Control_Unit_enum`):
  - `muldiv_op_e` enum for the funct3 encodings.
  - `muldiv_state_e` {IDLE, CALC, FIX, DONE}.
- Sub-module `muldiv_sign_fix`: combinational conditional two's-complement negate, parametrised width. Instantiated for operand magnitude and result fix-up.
- The FSM and shift/accumulate registers stay in the top module.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB, `done` at cycle 34, `busy` cycles 1–33.
- High-half products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Signed divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Special cases, each with `done` at cycle 1 and no `busy`:
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Abort and reset mid-operation:
  - MUL started, abort at cycle 10 → IDLE at 11, no `done`, `result` holds its previous value.
  - Start with abort high in the same CALC cycle → start ignored.
  - `rst` at cycle 20 → all outputs 0.
- Back-to-back: DIVU 100/7 then REMU 100/7, second start in the first DONE cycle → `done` with 14 at cycle 34, `done` with 2 at cycle 68.

Source files
------------

// File: rtl/MulDiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 ops, FSM states and
// small operand-class helpers.
package MulDiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_e;

  function automatic logic isDivOp(input muldiv_op_e op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  function automatic logic isRemOp(input muldiv_op_e op);
    return op inside {OpRem, OpRemu};
  endfunction

  function automatic logic signedA(input muldiv_op_e op);
    return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic signedB(input muldiv_op_e op);
    return op inside {OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle between the control unit (master) and the mul/div unit (slave).
interface riscv_muldiv_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  start;
  logic                  abort;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, abort, funct3, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, abort, funct3, a, b,
    output busy, done, result
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used both to take operand magnitudes and to
// restore result signs.
module muldiv_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] fixed
);

  assign fixed = negate ? ({WIDTH{1'b0}} - value) : value;

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with a final sign fix-up cycle.
module riscv_muldiv_unit
  import MulDiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input logic               clk,
  input logic               rst,
  riscv_muldiv_unit_if.slave bus
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(DATA_WIDTH);

  muldiv_state_e        stateQ, stateD;
  muldiv_op_e           opQ, opD;
  logic [CNT_WIDTH-1:0] cntQ, cntD;
  logic                 signAQ, signAD, signBQ, signBD;
  logic [2*W-1:0]       accQ, accD;
  logic [W-1:0]         mcandQ, mcandD;
  logic [W-1:0]         resultQ, resultD;

  // Request decode, evaluated only in the accept cycle.
  muldiv_op_e reqOp;
  logic       aNeg, bNeg, divByZero, overflow, accept;
  logic [W-1:0] aMag, bMag, specialRes;

  assign reqOp     = muldiv_op_e'(bus.funct3);
  assign aNeg      = signedA(reqOp) & bus.a[W-1];
  assign bNeg      = signedB(reqOp) & bus.b[W-1];
  assign divByZero = isDivOp(reqOp) && (bus.b == '0);
  assign overflow  = (reqOp inside {OpDiv, OpRem}) && (bus.a == MinNeg) && (bus.b == '1);
  assign accept    = bus.start && !bus.abort && (stateQ inside {IDLE, DONE});

  muldiv_sign_fix #(.WIDTH(W)) uAMag (.value(bus.a), .negate(aNeg), .fixed(aMag));
  muldiv_sign_fix #(.WIDTH(W)) uBMag (.value(bus.b), .negate(bNeg), .fixed(bMag));

  always_comb begin
    specialRes = '0;
    if (divByZero) begin
      specialRes = isRemOp(reqOp) ? bus.a : '1;
    end else begin
      specialRes = isRemOp(reqOp) ? '0 : bus.a;
    end
  end

  // Multiply step: add multiplicand into the high half when the LSB is set, then shift right.
  logic [W:0]     mulSum;
  logic [2*W-1:0] mulNext;
  assign mulSum  = {1'b0, accQ[2*W-1:W]} + {1'b0, mcandQ};
  assign mulNext = accQ[0] ? {mulSum, accQ[W-1:1]} : {1'b0, accQ[2*W-1:1]};

  // Restoring divide step: shift left, trial-subtract divisor from the partial remainder.
  logic [W:0]     divHi;
  logic [W-1:0]   divDiff;
  logic [2*W-1:0] divNext;
  assign divHi   = accQ[2*W-1:W-1];
  assign divDiff = divHi[W-1:0] - mcandQ;
  assign divNext = (divHi >= {1'b0, mcandQ}) ? {divDiff, accQ[W-2:0], 1'b1}
                                             : {divHi[W-1:0], accQ[W-2:0], 1'b0};

  logic [2*W-1:0] prodFixed;
  logic [W-1:0]   quoFixed, remFixed, fixRes;

  muldiv_sign_fix #(.WIDTH(2*W)) uProdFix (
    .value (accQ),
    .negate(signAQ ^ signBQ),
    .fixed (prodFixed)
  );
  muldiv_sign_fix #(.WIDTH(W)) uQuoFix (
    .value (accQ[W-1:0]),
    .negate(signAQ ^ signBQ),
    .fixed (quoFixed)
  );
  muldiv_sign_fix #(.WIDTH(W)) uRemFix (
    .value (accQ[2*W-1:W]),
    .negate(signAQ),
    .fixed (remFixed)
  );

  always_comb begin
    fixRes = '0;
    unique case (opQ)
      OpMul:                     fixRes = prodFixed[W-1:0];
      OpMulh, OpMulhsu, OpMulhu: fixRes = prodFixed[2*W-1:W];
      OpDiv, OpDivu:             fixRes = quoFixed;
      OpRem, OpRemu:             fixRes = remFixed;
      default:                   fixRes = '0;
    endcase
  end

  always_comb begin
    stateD  = stateQ;
    opD     = opQ;
    cntD    = cntQ;
    signAD  = signAQ;
    signBD  = signBQ;
    accD    = accQ;
    mcandD  = mcandQ;
    resultD = resultQ;
    unique case (stateQ)
      IDLE, DONE: begin
        stateD = IDLE;
        if (accept) begin
          opD  = reqOp;
          cntD = '0;
          if (divByZero || overflow) begin
            resultD = specialRes;
            stateD  = DONE;
          end else begin
            signAD = aNeg;
            signBD = bNeg;
            mcandD = bMag;
            accD   = {{W{1'b0}}, aMag};
            stateD = CALC;
          end
        end
      end
      CALC: begin
        if (bus.abort) begin
          stateD = IDLE;
        end else begin
          accD = isDivOp(opQ) ? divNext : mulNext;
          cntD = cntQ + CNT_WIDTH'(1);
          if (cntD == LastCnt) stateD = FIX;
        end
      end
      FIX: begin
        if (bus.abort) begin
          stateD = IDLE;
        end else begin
          resultD = fixRes;
          stateD  = DONE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ  <= IDLE;
      opQ     <= OpMul;
      cntQ    <= '0;
      signAQ  <= 1'b0;
      signBQ  <= 1'b0;
      accQ    <= '0;
      mcandQ  <= '0;
      resultQ <= '0;
    end else begin
      stateQ  <= stateD;
      opQ     <= opD;
      cntQ    <= cntD;
      signAQ  <= signAD;
      signBQ  <= signBD;
      accQ    <= accD;
      mcandQ  <= mcandD;
      resultQ <= resultD;
    end
  end

  assign bus.busy   = (stateQ == CALC) || (stateQ == FIX);
  assign bus.done   = (stateQ == DONE);
  assign bus.result = resultQ;

endmodule
